// File: rtl/msk_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | msk_pkg : shared constants and share-index helpers for masked gadgets    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package msk_pkg;

  localparam int MSK_MAX_LAT = 4;

  // Flat bit position of lane `lane`, share `share` in a count*d sharing bus.
  function automatic int share_idx(input int lane, input int share, input int d);
    return lane * d + share;
  endfunction

  function automatic bit cfg_ok(input int d, input int count, input int lat);
    return (d >= 1) && (count >= 1) && (lat >= 0) && (lat <= MSK_MAX_LAT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_inv_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | msk_inv_stage : one enabled register stage for W share bits plus valid  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module msk_inv_stage #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  // Data and valid share the same enable so an item never splits from its flag.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      data_d  = in_data;
      valid_d = in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/msk_inv_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | msk_inv_pipe : per-lane masked NOT on share 0, retimed by LAT stages     |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module msk_inv_pipe
  import msk_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [count-1:0]     inv_en,
  input  logic [count*d-1:0]   in,
  output logic [count*d-1:0]   out,
  output logic                 out_valid
);

  localparam int W = count * d;

  if (!cfg_ok(d, count, LAT)) begin : g_cfg_err
    $error("msk_inv_pipe: requires d>=1, count>=1, 0<=LAT<=MSK_MAX_LAT");
  end

  logic [W-1:0] s0_data;

  // Only share 0 of each lane sees inv_en; upper shares are plain wires.
  for (genvar i = 0; i < count; i++) begin : g_lane
    assign s0_data[share_idx(i, 0, d)] = in[share_idx(i, 0, d)] ^ inv_en[i];
    if (d > 1) begin : g_upper
      assign s0_data[share_idx(i, d-1, d):share_idx(i, 1, d)] =
             in[share_idx(i, d-1, d):share_idx(i, 1, d)];
    end
  end

  if (LAT == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign out         = s0_data;
    assign out_valid   = in_valid;
  end else begin : g_pipe
    logic [W-1:0] data_c  [0:LAT];
    logic         valid_c [0:LAT];

    assign data_c[0]  = s0_data;
    assign valid_c[0] = in_valid;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
      msk_inv_stage #(
        .W (W)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (data_c[s]),
        .in_valid  (valid_c[s]),
        .out_data  (data_c[s+1]),
        .out_valid (valid_c[s+1])
      );
    end

    assign out       = data_c[LAT];
    assign out_valid = valid_c[LAT];
  end

endmodule
`default_nettype wire

// File: tb/tb_msk_inv_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_msk_inv_pipe : five configurations driven from one stimulus bus       |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_msk_inv_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       stim_v = 1'b0;
  logic [7:0] stim_in = 8'd0;
  logic [3:0] stim_inv = 4'd0;

  logic [1:0] o1; logic v1;
  logic [5:0] o2; logic v2;
  logic [3:0] o3; logic v3;
  logic [1:0] o4; logic v4;
  logic [3:0] o5; logic v5;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  msk_inv_pipe #(.d(2), .count(1), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(stim_v), .inv_en(stim_inv[0:0]),
    .in(stim_in[1:0]), .out(o1), .out_valid(v1));
  msk_inv_pipe #(.d(3), .count(2), .LAT(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(stim_v), .inv_en(stim_inv[1:0]),
    .in(stim_in[5:0]), .out(o2), .out_valid(v2));
  msk_inv_pipe #(.d(2), .count(2), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(stim_v), .inv_en(stim_inv[1:0]),
    .in(stim_in[3:0]), .out(o3), .out_valid(v3));
  msk_inv_pipe #(.d(2), .count(1), .LAT(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(stim_v), .inv_en(stim_inv[0:0]),
    .in(stim_in[1:0]), .out(o4), .out_valid(v4));
  msk_inv_pipe #(.d(1), .count(4), .LAT(0)) u5 (
    .clk(clk), .rst(rst), .en(en), .in_valid(stim_v), .inv_en(stim_inv[3:0]),
    .in(stim_in[3:0]), .out(o5), .out_valid(v5));

  // Model: history of what was presented on each enabled, non-reset edge.
  logic [7:0] h_in  [4];
  logic [3:0] h_inv [4];
  logic       h_v   [4];
  int         mcnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0;
    end else if (en) begin
      for (int k = 3; k > 0; k--) begin
        h_in[k]  <= h_in[k-1];
        h_inv[k] <= h_inv[k-1];
        h_v[k]   <= h_v[k-1];
      end
      h_in[0]  <= stim_in;
      h_inv[0] <= stim_inv;
      h_v[0]   <= stim_v;
      mcnt     <= (mcnt < 4) ? mcnt + 1 : 4;
    end
  end

  function automatic logic [7:0] s0(input logic [7:0] x, input logic [3:0] iv,
                                    input int dd, input int cc);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < cc; i++)
      for (int j = 0; j < dd; j++)
        r[i*dd+j] = x[i*dd+j] ^ ((j == 0) ? iv[i] : 1'b0);
    return r;
  endfunction

  function automatic logic [8:0] model_out(input int dd, input int cc, input int l);
    if (l == 0) return {stim_v, s0(stim_in, stim_inv, dd, cc)};
    if (mcnt < l) return 9'd0;
    return {h_v[l-1], s0(h_in[l-1], h_inv[l-1], dd, cc)};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got valid/data %h, want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    chk("cmp_u1", {v1, 6'd0, o1}, model_out(2, 1, 1));
    chk("cmp_u2", {v2, 2'd0, o2}, model_out(3, 2, 2));
    chk("cmp_u3", {v3, 4'd0, o3}, model_out(2, 2, 3));
    chk("cmp_u4", {v4, 6'd0, o4}, model_out(2, 1, 4));
    chk("cmp_u5", {v5, 4'd0, o5}, model_out(1, 4, 0));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    edge1(); edge1();
    rst = 1'b0;

    // Test 1: d=2 count=1 LAT=1
    chk("t1_reset", {v1, 6'd0, o1}, 9'd0);
    stim_in = 8'b10; stim_inv = 4'b1; stim_v = 1'b1; en = 1'b1;
    edge1();
    chk("t1_out", {v1, 6'd0, o1}, {1'b1, 8'b11});
    chk("t1_recomb", {8'd0, ^o1}, {8'd0, ~(^2'b10)});

    // Test 2: d=3 count=2 LAT=2
    stim_in = 8'b0010_1011; stim_inv = 4'b0010;
    edge1(); edge1();
    chk("t2_out", {v2, 2'd0, o2}, {1'b1, 8'b0010_0011});
    chk("t2_upper", {3'd0, o2 & 6'b110110}, {3'd0, 6'b100010});

    // Test 3: stall on LAT=3
    do_reset();
    stim_in = 8'b0110; stim_inv = 4'b01; stim_v = 1'b1; en = 1'b1;
    edge1();
    stim_in = 8'b0101; stim_inv = 4'b11; en = 1'b0;
    edge1(); edge1();
    chk("t3_stall_v", {8'd0, v3}, 9'd0);
    stim_in = 8'b1001; stim_inv = 4'b10; en = 1'b1;
    edge1();
    stim_in = 8'b1111; stim_inv = 4'b11;
    edge1();
    chk("t3_A", {v3, 4'd0, o3}, {1'b1, 8'b0111});
    stim_in = 8'd0; stim_inv = 4'd0; stim_v = 1'b0;
    edge1();
    chk("t3_B", {v3, 4'd0, o3}, {1'b1, 8'b1101});
    edge1();
    chk("t3_C", {v3, 4'd0, o3}, {1'b1, 8'b1010});
    edge1();
    chk("t3_drain", {8'd0, v3}, 9'd0);

    // Test 4: reset mid-stream on LAT=4
    do_reset();
    stim_in = 8'b10; stim_inv = 4'd0; stim_v = 1'b1; en = 1'b1;
    for (int k = 0; k < 6; k++) edge1();
    chk("t4_pre", {v4, 6'd0, o4}, {1'b1, 8'b10});
    #2 rst = 1'b1;
    #1;
    chk("t4_async_u4", {v4, 6'd0, o4}, 9'd0);
    chk("t4_async_u3", {v3, 4'd0, o3}, 9'd0);
    edge1();
    chk("t4_rst_wins", {v4, 6'd0, o4}, 9'd0);
    rst = 1'b0; stim_v = 1'b0; stim_in = 8'd0;
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk("t4_post_v", {8'd0, v4}, 9'd0);
    end

    // Test 5: LAT=0 d=1 count=4
    en = 1'b0;
    stim_in = 8'b1010; stim_inv = 4'b0110; stim_v = 1'b1;
    #1;
    chk("t5_out", {v5, 4'd0, o5}, {1'b1, 8'b1100});
    stim_v = 1'b0;
    #1;
    chk("t5_valid", {v5, 4'd0, o5}, {1'b0, 8'b1100});

    // Test 6: random regression on all configurations
    edge1();
    for (int k = 0; k < 400; k++) begin
      stim_in  = 8'($urandom);
      stim_inv = 4'($urandom);
      stim_v   = 1'($urandom);
      en       = ($urandom_range(3) != 0);
      rst      = ($urandom_range(49) == 0);
      edge1();
    end
    rst = 1'b0;
    edge1(); edge1();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msk_inv_pipe.md
# msk_inv_pipe

Pipelined, multi-lane masked inverter for Boolean-masked datapaths. Applies a run-time, per-lane public inversion to `count` d-share sharings and carries the result through `LAT` register stages with a stall enable and a valid flag. Used where a masked NOT must be retimed to line up with sibling gadgets of matching latency. It touches only share 0, so it adds no randomness and keeps the affine/isolated security property.

## Interface
- `d`, 2, number of shares per lane (≥1)
- `count`, 1, number of independent lanes (≥1)
- `LAT`, 1, register stages between input and output (0..4)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  stage advance enable; low = whole pipeline holds
- `in_valid`  in  1  input sharing is meaningful this cycle
- `inv_en`  in  count  public per-lane control; bit i set = invert lane i
- `in`  in  count*d  input sharings; lane i share j at bit i*d+j
- `out`  out  count*d  output sharings, same layout
- `out_valid`  out  1  `out` is meaningful

## Operation
- Stage-0 function, per lane i:
  - share 0 becomes `in[i*d] ^ inv_en[i]`.
  - Shares 1..d-1 pass unchanged.
  - `inv_en` applies in the cycle the sharing is presented, not at the output.
- Pure share-wise logic only:
  - no cross-share gates;
  - no combinational path from share j≥1 to share 0, or the reverse;
  - `inv_en` affects share 0 only.
- LAT=0:
  - `out` is the stage-0 function of `in`, combinational;
  - `out_valid = in_valid`;
  - `clk`, `rst` and `en` are ignored.
- LAT≥1:
  - chain of LAT identical stages, each holding count*d share bits plus 1 valid bit;
  - on a rising edge with `en=1`, every stage loads its predecessor; stage 1 loads the stage-0 function of `in` and `in_valid`;
  - `en=0`: all stages, including valid bits, hold.
- The valid bit is qualification only. Data registers load regardless of `in_valid`. No bubble collapsing, no backpressure beyond `en`.
- d=1 is legal and reduces to an unmasked, registered NOT.

## Timing
- Latency: exactly LAT enabled edges from `in`/`inv_en` to `out`. Cycles with `en=0` do not count.
- Throughput: one sharing per enabled cycle.
- Reset (`rst=1`, asynchronous):
  - all data registers go to 0, so `out` = all-zero (a valid sharing of 0);
  - all valid bits go to 0, so `out_valid=0`;
  - this holds immediately, independent of `clk`.
- Release: the first load occurs on the first rising edge with `rst=0` and `en=1`.
- Reset mid-stream: in-flight sharings are discarded. No partial outputs appear after release; `out_valid` stays 0 until LAT enabled edges of fresh data.
- Simultaneous `en=1` and `rst=1`: reset wins.
- `en` toggling: the data/valid pairing is preserved exactly. An item never advances without its valid bit, and the reverse.
- Outputs of LAT≥1 come straight from flops. No combinational input→output path.

## Structure
- Shared package `msk_pkg`:
  - share-slice helper functions (lane i, share j index = i*d+j);
  - constant `MSK_MAX_LAT=4`;
  - elaboration check: `d≥1`, `count≥1`, `LAT≤MSK_MAX_LAT`.
- Sub-module `msk_inv_stage`:
  - one enabled register stage for count*d data plus valid, with async reset;
  - instantiated LAT times by a generate loop.
- Top-level: stage-0 inversion logic plus the generate chain, with an LAT=0 bypass branch.

## Test plan
1. d=2, count=1, LAT=1:
   - stimulus: rst pulse; check out=2'b00, out_valid=0. Then in=2'b10, inv_en=1, in_valid=1, en=1, one edge.
   - response: out=2'b11, out_valid=1; recombined value = NOT of input value.
2. d=3, count=2, LAT=2:
   - stimulus: in=6'b101_011, inv_en=2'b10, en held 1.
   - response: after 2 edges out=6'b100_011 (only lane-1 share 0 flipped).
   - also check: every share j≥1 equals the input bit-for-bit.
3. Stall: LAT=3, stream values A,B,C with en low for 2 cycles between A and B.
   - response: output order A,B,C; each arrives after exactly 3 enabled edges; out_valid never set for stalled-in garbage.
4. Reset mid-stream: LAT=4, 3 items in flight, assert rst between edges.
   - response: out and out_valid drop to 0 without a clock edge.
   - after release with in_valid=0: out_valid stays 0 for ≥4 enabled edges.
5. LAT=0, d=1, count=4:
   - stimulus: in=4'b1010, inv_en=4'b0110.
   - response: out=4'b1100 the same cycle; out_valid follows in_valid combinationally.
6. Random regression, all (d, count, LAT) in a small grid.
   - response: the XOR of each lane's output shares equals the XOR of its input shares ^ inv_en, delayed LAT enabled edges.
   - the golden model is checked against every enabled edge.
